// File: rtl/advanced_fifo_controller_if.sv
// User-side handshake bundle of the FIFO controller: write request/data,
// read request and the read data returned by the controller.
interface advanced_fifo_controller_if #(
    parameter int WIDTH = 8
);
    logic             write_enable;
    logic [WIDTH-1:0] write_data;
    logic             read_enable;
    logic [WIDTH-1:0] read_data;

    // Producer/consumer side drives requests and samples read data.
    modport master (
        output write_enable,
        output write_data,
        output read_enable,
        input  read_data
    );

    // FIFO controller side.
    modport slave (
        input  write_enable,
        input  write_data,
        input  read_enable,
        output read_data
    );
endinterface

// File: rtl/advanced_fifo_controller.sv
// FIFO controller for an external memory with combinational read.
// Pointers are kept as address plus lap bit so any DEPTH >= 2 works.
// Optional sticky overflow/underflow flags are built only when the macro
// ADVANCED_FIFO_CONTROLLER_ERROR_FLAGS_EN is defined; otherwise both flags
// are tied low and clear_errors is ignored.
module advanced_fifo_controller #(
    parameter int WIDTH                  = 8,
    parameter int DEPTH                  = 4,
    parameter int DEPTH_LOG2             = $clog2(DEPTH),
    parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 1,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    advanced_fifo_controller_if.slave bus,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear_errors,
    output logic                  memory_clock,
    output logic                  memory_write_enable,
    output logic [DEPTH_LOG2-1:0] memory_write_address,
    output logic [WIDTH-1:0]      memory_write_data,
    output logic                  memory_read_enable,
    output logic [DEPTH_LOG2-1:0] memory_read_address,
    input  logic [WIDTH-1:0]      memory_read_data
);
    localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);

    logic [DEPTH_LOG2-1:0] wr_addr_reg, wr_addr_next;
    logic [DEPTH_LOG2-1:0] rd_addr_reg, rd_addr_next;
    logic                  wr_lap_reg, wr_lap_next;
    logic                  rd_lap_reg, rd_lap_next;
    logic [DEPTH_LOG2:0]   level_reg, level_next;
    logic                  write_accept;
    logic                  read_accept;

    // Same address: lap bits tell an empty FIFO from a full one.
    assign empty = (wr_addr_reg == rd_addr_reg) && (wr_lap_reg == rd_lap_reg);
    assign full  = (wr_addr_reg == rd_addr_reg) && (wr_lap_reg != rd_lap_reg);

    // Requests are qualified by pre-edge status, so a write on full or a
    // read on empty never reaches the memory.
    assign write_accept = bus.write_enable && !full;
    assign read_accept  = bus.read_enable && !empty;

    assign level        = level_reg;
    assign almost_full  = (int'(level_reg) >= ALMOST_FULL_THRESHOLD);
    assign almost_empty = (int'(level_reg) <= ALMOST_EMPTY_THRESHOLD);

    assign memory_clock         = clock;
    assign memory_write_enable  = write_accept;
    assign memory_write_address = wr_addr_reg;
    assign memory_write_data    = bus.write_data;
    assign memory_read_enable   = read_accept;
    assign memory_read_address  = rd_addr_reg;
    assign bus.read_data        = memory_read_data;

    // Next pointer and level values from the accepted operations.
    always_comb begin
        wr_addr_next = wr_addr_reg;
        wr_lap_next  = wr_lap_reg;
        rd_addr_next = rd_addr_reg;
        rd_lap_next  = rd_lap_reg;
        level_next   = level_reg;
        if (write_accept) begin
            if (wr_addr_reg == LAST_ADDR) begin
                wr_addr_next = '0;
                wr_lap_next  = !wr_lap_reg;
            end else begin
                wr_addr_next = wr_addr_reg + 1'b1;
            end
        end
        if (read_accept) begin
            if (rd_addr_reg == LAST_ADDR) begin
                rd_addr_next = '0;
                rd_lap_next  = !rd_lap_reg;
            end else begin
                rd_addr_next = rd_addr_reg + 1'b1;
            end
        end
        case ({write_accept, read_accept})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Pointer and level registers; reset discards all stored contents.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_addr_reg <= '0;
            wr_lap_reg  <= 1'b0;
            rd_addr_reg <= '0;
            rd_lap_reg  <= 1'b0;
            level_reg   <= '0;
        end else begin
            wr_addr_reg <= wr_addr_next;
            wr_lap_reg  <= wr_lap_next;
            rd_addr_reg <= rd_addr_next;
            rd_lap_reg  <= rd_lap_next;
            level_reg   <= level_next;
        end
    end

`ifdef ADVANCED_FIFO_CONTROLLER_ERROR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (bus.write_enable && full)
                overflow_reg <= 1'b1;
            else if (clear_errors)
                overflow_reg <= 1'b0;
            if (bus.read_enable && empty)
                underflow_reg <= 1'b1;
            else if (clear_errors)
                underflow_reg <= 1'b0;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`else
    logic unused_clear_errors;

    assign unused_clear_errors = clear_errors;
    assign overflow            = 1'b0;
    assign underflow           = 1'b0;
`endif
endmodule

// File: tb/tb_advanced_fifo_controller.sv
// Directed testbench for advanced_fifo_controller (WIDTH=8, DEPTH=5,
// thresholds 4/1) with a behavioural memory that reads combinationally.
module tb_advanced_fifo_controller;
`ifdef ADVANCED_FIFO_CONTROLLER_ERROR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       clear_errors;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] level;
    logic       overflow, underflow;
    logic       mem_clk, mwe, mre;
    logic [2:0] mwa, mra;
    logic [7:0] mwd, mrd;
    logic [7:0] mem_array [0:7];

    int checks = 0;
    int errors = 0;
    int wa = 0;
    int ra = 0;
    logic [7:0] q [$];
    logic [7:0] exp_d;

    advanced_fifo_controller_if #(.WIDTH(8)) bus ();

    advanced_fifo_controller #(
        .WIDTH(8), .DEPTH(5), .ALMOST_FULL_THRESHOLD(4), .ALMOST_EMPTY_THRESHOLD(1)
    ) dut (
        .clock(clock), .resetn(resetn), .bus(bus),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow), .clear_errors(clear_errors),
        .memory_clock(mem_clk), .memory_write_enable(mwe), .memory_write_address(mwa),
        .memory_write_data(mwd), .memory_read_enable(mre), .memory_read_address(mra),
        .memory_read_data(mrd)
    );

    always #5 clock = ~clock;

    always @(posedge mem_clk) if (mwe) mem_array[mwa] <= mwd;
    assign mrd = mem_array[mra];

    task automatic drive(input logic we, input logic [7:0] wd, input logic re);
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.read_enable  = re;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; clear_errors = 1'b0;
        bus.write_enable = 1'b0; bus.read_enable = 1'b0; bus.write_data = 8'h00;
        #2;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b udf=%b want 0 0", overflow, underflow); end
        #5 resetn = 1'b1;
        @(posedge clock); #1;
        $display("reset released: level=%0d empty=%b", level, empty);
    endtask

    task automatic test_fill_drain();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'(8'h11 * k), 1'b0);
            checks++; if (mwe !== 1'b1 || mwa !== 3'(wa)) begin errors++; $display("FAIL fill_mem got we=%b addr=%0d want we=1 addr=%0d", mwe, mwa, wa); end
            tick();
            q.push_back(8'(8'h11 * k)); wa = (wa + 1) % 5;
            $display("write %h: level=%0d full=%b af=%b", 8'(8'h11 * k), level, full, almost_full);
            checks++; if (level !== 4'(k)) begin errors++; $display("FAIL fill_level got %0d want %0d", level, k); end
            checks++; if (full !== (k == 5) || empty !== 1'b0) begin errors++; $display("FAIL fill_status got full=%b empty=%b want full=%b empty=0", full, empty, (k == 5)); end
            checks++; if (almost_full !== (k >= 4) || almost_empty !== (k <= 1)) begin errors++; $display("FAIL fill_almost got af=%b ae=%b want af=%b ae=%b", almost_full, almost_empty, (k >= 4), (k <= 1)); end
        end
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            checks++; if (mre !== 1'b1 || mra !== 3'(ra)) begin errors++; $display("FAIL drain_mem got re=%b addr=%0d want re=1 addr=%0d", mre, mra, ra); end
            checks++; if (bus.read_data !== 8'(8'h11 * k)) begin errors++; $display("FAIL drain_data got %h want %h", bus.read_data, 8'(8'h11 * k)); end
            tick();
            void'(q.pop_front()); ra = (ra + 1) % 5;
            $display("read %h: level=%0d empty=%b", 8'(8'h11 * k), level, empty);
            checks++; if (level !== 4'(5 - k) || empty !== (k == 5) || full !== 1'b0) begin errors++; $display("FAIL drain_status got level=%0d empty=%b full=%b want %0d %b 0", level, empty, full, 5 - k, (k == 5)); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'(8'hC0 + k), 1'b0);
            tick();
            q.push_back(8'(8'hC0 + k)); wa = (wa + 1) % 5;
        end
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'hD0 + i), 1'b1);
            exp_d = q[0];
            checks++; if (bus.read_data !== exp_d) begin errors++; $display("FAIL b2b_data got %h want %h", bus.read_data, exp_d); end
            checks++; if (mwe !== 1'b1 || mre !== 1'b1 || mwa !== 3'(wa) || mra !== 3'(ra)) begin errors++; $display("FAIL b2b_mem got we=%b re=%b wa=%0d ra=%0d want 1 1 %0d %0d", mwe, mre, mwa, mra, wa, ra); end
            tick();
            void'(q.pop_front()); q.push_back(8'(8'hD0 + i));
            wa = (wa + 1) % 5; ra = (ra + 1) % 5;
            $display("pair %0d: wrote %h read %h level=%0d", i, 8'(8'hD0 + i), exp_d, level);
            checks++; if (level !== 4'd2 || full !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL b2b_status got level=%0d full=%b empty=%b want 2 0 0", level, full, empty); end
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            exp_d = q.pop_front();
            checks++; if (bus.read_data !== exp_d) begin errors++; $display("FAIL b2b_drain got %h want %h", bus.read_data, exp_d); end
            tick();
            ra = (ra + 1) % 5;
        end
        checks++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL b2b_end got empty=%b level=%0d want 1 0", empty, level); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            tick();
            q.push_back(8'(k)); wa = (wa + 1) % 5;
        end
        drive(1'b1, 8'h99, 1'b0);
        checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL ovf_mem_we got %b want 0", mwe); end
        tick();
        $display("write 99 on full: level=%0d overflow=%b", level, overflow);
        checks++; if (level !== 4'd5 || full !== 1'b1) begin errors++; $display("FAIL ovf_level got level=%0d full=%b want 5 1", level, full); end
        checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got %b want %b", overflow, ERR_EN); end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_full_both();
        drive(1'b1, 8'h77, 1'b1);
        exp_d = q[0];
        checks++; if (mwe !== 1'b0 || mre !== 1'b1) begin errors++; $display("FAIL fb_mem got we=%b re=%b want 0 1", mwe, mre); end
        checks++; if (bus.read_data !== exp_d) begin errors++; $display("FAIL fb_data got %h want %h", bus.read_data, exp_d); end
        tick();
        void'(q.pop_front()); ra = (ra + 1) % 5;
        $display("read+write 77 on full: level=%0d full=%b", level, full);
        checks++; if (level !== 4'd4 || full !== 1'b0) begin errors++; $display("FAIL fb_level got level=%0d full=%b want 4 0", level, full); end
        drive(1'b1, 8'h77, 1'b0);
        checks++; if (mwe !== 1'b1) begin errors++; $display("FAIL fb_retry_we got %b want 1", mwe); end
        tick();
        q.push_back(8'h77); wa = (wa + 1) % 5;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            exp_d = q.pop_front();
            checks++; if (bus.read_data !== exp_d) begin errors++; $display("FAIL fb_drain got %h want %h", bus.read_data, exp_d); end
            tick();
            ra = (ra + 1) % 5;
            $display("read %h: level=%0d", exp_d, level);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fb_empty got %b want 1", empty); end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    task automatic test_empty_both();
        drive(1'b1, 8'hA5, 1'b1);
        checks++; if (mre !== 1'b0 || mwe !== 1'b1) begin errors++; $display("FAIL eb_mem got re=%b we=%b want 0 1", mre, mwe); end
        tick();
        wa = (wa + 1) % 5;
        $display("read+write a5 on empty: level=%0d underflow=%b", level, underflow);
        checks++; if (level !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL eb_level got level=%0d empty=%b want 1 0", level, empty); end
        checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL eb_underflow got %b want %b", underflow, ERR_EN); end
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (bus.read_data !== 8'hA5) begin errors++; $display("FAIL eb_data got %h want a5", bus.read_data); end
        tick();
        ra = (ra + 1) % 5;
        checks++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL eb_drain got empty=%b level=%0d want 1 0", empty, level); end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL eb_clear got %b want 0", underflow); end
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 8'(8'h30 + k), 1'b0);
            tick();
        end
        checks++; if (level !== 4'd3) begin errors++; $display("FAIL ar_prefill got %0d want 3", level); end
        #2 resetn = 1'b0;
        #1;
        $display("async reset at level 3: level=%0d empty=%b", level, empty);
        checks++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL ar_state got empty=%b level=%0d full=%b want 1 0 0", empty, level, full); end
        checks++; if (almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL ar_flags got ae=%b ovf=%b udf=%b want 1 0 0", almost_empty, overflow, underflow); end
        #1 resetn = 1'b1;
        @(posedge clock); #1;
        q.delete(); wa = 0; ra = 0;
        drive(1'b1, 8'h3C, 1'b0);
        checks++; if (mwe !== 1'b1 || mwa !== 3'd0) begin errors++; $display("FAIL ar_write got we=%b addr=%0d want 1 0", mwe, mwa); end
        tick();
        drive(1'b0, 8'h00, 1'b1);
        checks++; if (mra !== 3'd0 || bus.read_data !== 8'h3C) begin errors++; $display("FAIL ar_read got addr=%0d data=%h want 0 3c", mra, bus.read_data); end
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_end got empty=%b want 1", empty); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_array[i] = 8'h00;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_overflow();
        test_full_both();
        test_empty_both();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
